i2c_bit_ctrl: RTL and testbench

I2C bit-level sequencer that owns the SCL timebase of the AXI-Stream I2C master. It accepts one bus primitive per handshake (START, STOP, WRITE bit, READ bit) and runs it as four equal quarter-period phases timed by an internal prescaler. It drives open-drain SCL/SDA enables, honours slave clock stretching and returns the sampled SDA bit. The byte-level controller sits above it; the pad wrapper sits below it.

---
 rtl/i2c_pkg.sv | 79 +++++++
 rtl/i2c_tick_gen.sv | 48 ++++
 rtl/i2c_bit_ctrl.sv | 173 +++++++++++++++++
 tb/tb_i2c_bit_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared definitions for the I2C bit-level sequencer:
//   i2c_cmd_t   - bus primitive accepted by i2c_bit_ctrl (START/STOP/WRITE/READ)
//   i2c_phase_t - sequencer state (IDLE plus the four quarter-period phases)
//   qtr_calc    - system clocks per quarter SCL period
//   phase_lines - open-drain enables {scl, sda} a primitive drives in a phase
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } i2c_cmd_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    PH_C = 3'd3,
    PH_D = 3'd4
  } i2c_phase_t;

  // Integer division on purpose: any remainder makes SCL slightly fast.
  function automatic int qtr_calc(input int clk_in, input int scl_freq);
    return clk_in / (4 * scl_freq);
  endfunction

  // Returns {scl, sda} enables (1 = release). START phase A keeps the current
  // SCL level so the same primitive serves as a repeated start after a data bit.
  function automatic logic [1:0] phase_lines(input i2c_cmd_t   cmd,
                                             input logic       din,
                                             input i2c_phase_t ph,
                                             input logic       scl_hold);
    logic [1:0] lines;
    lines = 2'b11;
    case (cmd)
      CMD_START: begin
        case (ph)
          PH_A:    lines = {scl_hold, 1'b1};
          PH_B:    lines = 2'b11;
          PH_C:    lines = 2'b10;
          PH_D:    lines = 2'b00;
          default: lines = 2'b11;
        endcase
      end
      CMD_STOP: begin
        case (ph)
          PH_A:    lines = 2'b00;
          PH_B:    lines = 2'b10;
          PH_C:    lines = 2'b11;
          PH_D:    lines = 2'b11;
          default: lines = 2'b11;
        endcase
      end
      CMD_WRITE: begin
        case (ph)
          PH_A:    lines = {1'b0, din};
          PH_B:    lines = {1'b1, din};
          PH_C:    lines = {1'b1, din};
          PH_D:    lines = {1'b0, din};
          default: lines = 2'b11;
        endcase
      end
      CMD_READ: begin
        case (ph)
          PH_A:    lines = 2'b01;
          PH_B:    lines = 2'b11;
          PH_C:    lines = 2'b11;
          PH_D:    lines = 2'b01;
          default: lines = 2'b11;
        endcase
      end
      default: lines = 2'b11;
    endcase
    return lines;
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen
// Quarter-period prescaler: a loadable down-counter that stops at zero.
// Ports:
//   clk    in  system clock
//   arstn  in  asynchronous active-low reset (counter clears to 0)
//   load   in  reload the counter with QTR-1 (takes priority over freeze)
//   freeze in  hold the counter this cycle (slave clock stretching)
//   tick   out counter is at zero and not frozen: the current phase ends
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int QTR = 4
) (
  input  logic clk,
  input  logic arstn,
  input  logic load,
  input  logic freeze,
  output logic tick
);

  localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(QTR - 1);

  // Fewer than two clocks per quarter leaves no room for a phase to exist.
  if (QTR < 2) begin : g_qtr_too_small
    $error("i2c_tick_gen: QTR must be at least 2");
  end

  logic [CW-1:0] cnt;

  // A frozen counter never ticks, so a stretched phase grows by exactly the
  // number of frozen cycles.
  assign tick = (cnt == {CW{1'b0}}) && !freeze;

  // Down-counter: reload, hold while frozen, otherwise count down to zero.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt <= {CW{1'b0}};
    end else if (load) begin
      cnt <= RELOAD;
    end else if (!freeze && (cnt != {CW{1'b0}})) begin
      cnt <= cnt - CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/i2c_bit_ctrl.sv
// i2c_bit_ctrl
// I2C bit-level sequencer owning the SCL timebase. Runs one bus primitive
// (START, STOP, WRITE bit, READ bit) per handshake as four quarter-period
// phases, drives open-drain enables, honours clock stretching and returns the
// SDA level sampled at the end of phase C.
// Ports:
//   clk_i, arstn_i   clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o, cmd_i, din_i   command handshake and payload
//   rsp_valid_o, rsp_dout_o                 one-cycle completion + sampled bit
//   busy_o                                  command in progress
//   scl_o, sda_o     open-drain enables (1 = release, 0 = pull low)
//   scl_i, sda_i     synchronised bus levels
module i2c_bit_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_IN   = 100_000_000,
  parameter int SCL_FREQ = 100_000
) (
  input  logic       clk_i,
  input  logic       arstn_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic       din_i,
  output logic       rsp_valid_o,
  output logic       rsp_dout_o,
  output logic       busy_o,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int QTR = qtr_calc(CLK_IN, SCL_FREQ);

  i2c_phase_t state;
  i2c_phase_t next_state;
  i2c_cmd_t   cmd_q;
  logic       din_q;
  logic       tick;
  logic       load;
  logic       freeze;
  logic       accept;
  logic       next_scl;
  logic       next_sda;

  assign accept = cmd_valid_i && cmd_ready_o;
  // We released SCL but the bus is still low: a slave is stretching.
  assign freeze = scl_o && !scl_i;

  i2c_tick_gen #(
    .QTR(QTR)
  ) u_tick_gen (
    .clk   (clk_i),
    .arstn (arstn_i),
    .load  (load),
    .freeze(freeze),
    .tick  (tick)
  );

  // Next state and next line levels; levels change only on the edge that
  // enters a phase, and the phase D levels persist through IDLE.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    next_scl   = scl_o;
    next_sda   = sda_o;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = PH_A;
          load       = 1'b1;
          {next_scl, next_sda} = phase_lines(i2c_cmd_t'(cmd_i), din_i, PH_A, scl_o);
        end else begin
          next_state = IDLE;
        end
      end
      PH_A: begin
        if (tick) begin
          next_state = PH_B;
          load       = 1'b1;
          {next_scl, next_sda} = phase_lines(cmd_q, din_q, PH_B, scl_o);
        end else begin
          next_state = PH_A;
        end
      end
      PH_B: begin
        if (tick) begin
          next_state = PH_C;
          load       = 1'b1;
          {next_scl, next_sda} = phase_lines(cmd_q, din_q, PH_C, scl_o);
        end else begin
          next_state = PH_B;
        end
      end
      PH_C: begin
        if (tick) begin
          next_state = PH_D;
          load       = 1'b1;
          {next_scl, next_sda} = phase_lines(cmd_q, din_q, PH_D, scl_o);
        end else begin
          next_state = PH_C;
        end
      end
      PH_D: begin
        // No reload here: the counter rests at zero while idle.
        if (tick) begin
          next_state = IDLE;
        end else begin
          next_state = PH_D;
        end
      end
      default: begin
        next_state = IDLE;
        next_scl   = 1'b1;
        next_sda   = 1'b1;
      end
    endcase
  end

  // Sequencer state and registered line enables; reset releases both lines.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state <= IDLE;
      scl_o <= 1'b1;
      sda_o <= 1'b1;
    end else begin
      state <= next_state;
      scl_o <= next_scl;
      sda_o <= next_sda;
    end
  end

  // Command latch so cmd_i/din_i may change freely while busy.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cmd_q <= CMD_START;
      din_q <= 1'b0;
    end else if (accept) begin
      cmd_q <= i2c_cmd_t'(cmd_i);
      din_q <= din_i;
    end else begin
      cmd_q <= cmd_q;
      din_q <= din_q;
    end
  end

  // Handshake/status flags, registered from the next state so that the first
  // IDLE cycle already shows ready and a back-to-back command can be taken.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
    end else begin
      cmd_ready_o <= (next_state == IDLE);
      busy_o      <= (next_state != IDLE);
      rsp_valid_o <= (state == PH_D) && tick;
    end
  end

  // SDA sample at the end of phase C (read data, or ACK/arbitration on write).
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rsp_dout_o <= 1'b0;
    end else if ((state == PH_C) && tick) begin
      rsp_dout_o <= sda_i;
    end else begin
      rsp_dout_o <= rsp_dout_o;
    end
  end

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Testbench for i2c_bit_ctrl with QTR = 4 (1.6 MHz clock, 100 kHz SCL).
// Bus is wired-AND of DUT enables and a simple slave model. Expected
// responses are queued when a command is driven and popped on rsp_valid_o.
module tb_i2c_bit_ctrl;

  localparam int QTR = 4;
  localparam int CMD_LEN = 4 * QTR;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic       din = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_dout, busy, scl_o, sda_o;
  logic       slave_scl = 1'b1;
  logic       slave_sda = 1'b1;
  logic       scl_bus, sda_bus;

  int cyc = 0;    // number of rising edges so far
  int total = 0;
  int bad = 0;

  typedef struct {
    logic dout;
    int   cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  assign scl_bus = scl_o & slave_scl;
  assign sda_bus = sda_o & slave_sda;

  i2c_bit_ctrl #(
    .CLK_IN  (1_600_000),
    .SCL_FREQ(100_000)
  ) dut (
    .clk_i      (clk),
    .arstn_i    (arstn),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_i      (cmd),
    .din_i      (din),
    .rsp_valid_o(rsp_valid),
    .rsp_dout_o (rsp_dout),
    .busy_o     (busy),
    .scl_o      (scl_o),
    .sda_o      (sda_o),
    .scl_i      (scl_bus),
    .sda_i      (sda_bus)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected {scl, sda} enables for command c in phase ph (0..3 = A..D).
  function automatic logic [1:0] exp_lines(input logic [1:0] c, input logic d,
                                           input int ph, input logic hold_scl);
    logic [1:0] r;
    r = 2'b11;
    case (c)
      2'd0:    r = (ph == 0) ? {hold_scl, 1'b1} : (ph == 1) ? 2'b11 : (ph == 2) ? 2'b10 : 2'b00;
      2'd1:    r = (ph == 0) ? 2'b00 : (ph == 1) ? 2'b10 : 2'b11;
      2'd2:    r = {((ph == 1) || (ph == 2)), d};
      default: r = (ph == 0 || ph == 3) ? 2'b01 : 2'b11;
    endcase
    return r;
  endfunction

  // Response monitor: each pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (arstn && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_spurious", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_dout", rsp_dout, e.dout);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", cmd_ready, 1);
  endtask

  // Drive one command, check the line levels every cycle of its four phases.
  // stretch > 0 makes the slave hold SCL low that many cycles from PH_B entry.
  task automatic run_cmd(input string tag, input logic [1:0] c, input logic d,
                         input logic s_sda, input int stretch, input logic exp_dout);
    int         t0;
    int         ph;
    logic       hold;
    logic [1:0] lv;
    exp_t       x;
    wait_ready();
    slave_sda = s_sda;
    hold = scl_o;
    t0 = cyc + 1;  // the edge that accepts the command
    cmd = c;
    din = d;
    cmd_valid = 1'b1;
    x.dout = exp_dout;
    x.cyc = t0 + CMD_LEN + stretch;
    exp_q.push_back(x);
    for (int k = 0; k < CMD_LEN + stretch; k++) begin
      @(negedge clk);
      if (k == 0) begin
        cmd_valid = 1'b0;
        cmd = 2'($urandom_range(0, 3));
        din = 1'($urandom_range(0, 1));
      end
      if (stretch > 0 && k == QTR) slave_scl = 1'b0;
      if (k == QTR + stretch) slave_scl = 1'b1;
      ph = (k < QTR) ? 0 : (k < 2 * QTR + stretch) ? 1 : (k < 3 * QTR + stretch) ? 2 : 3;
      lv = exp_lines(c, d, ph, hold);
      chk({tag, "_scl"}, scl_o, lv[1]);
      chk({tag, "_sda"}, sda_o, lv[0]);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_ready"}, cmd_ready, 0);
      chk({tag, "_rspv"}, rsp_valid, 0);
    end
  endtask

  initial begin
    int   acc;
    int   nrsp;
    exp_t x;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_scl", scl_o, 1);
    chk("rst_sda", sda_o, 1);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_dout", rsp_dout, 0);
    arstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_scl", scl_o, 1);
    chk("idle_sda", sda_o, 1);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);

    // Primitives, issued back to back
    run_cmd("start", 2'd0, 1'b0, 1'b1, 0, 1'b0);
    run_cmd("stop", 2'd1, 1'b0, 1'b1, 0, 1'b1);
    run_cmd("start2", 2'd0, 1'b0, 1'b1, 0, 1'b0);
    run_cmd("wr0_ack", 2'd2, 1'b0, 1'b0, 0, 1'b0);
    run_cmd("wr1_rel", 2'd2, 1'b1, 1'b1, 0, 1'b1);
    run_cmd("wr1_ack", 2'd2, 1'b1, 1'b0, 0, 1'b0);
    run_cmd("rd0", 2'd3, 1'b0, 1'b0, 0, 1'b0);
    run_cmd("rd1", 2'd3, 1'b0, 1'b1, 0, 1'b1);
    run_cmd("wr_stretch", 2'd2, 1'b1, 1'b1, 10, 1'b1);
    run_cmd("rstart", 2'd0, 1'b0, 1'b1, 0, 1'b0);
    run_cmd("stop2", 2'd1, 1'b0, 1'b1, 0, 1'b1);

    // Async reset in the middle of WRITE din=0: no response may follow
    wait_ready();
    slave_sda = 1'b0;
    cmd = 2'd2;
    din = 1'b0;
    cmd_valid = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 0) cmd_valid = 1'b0;
    end
    chk("arst_pre_sda", sda_o, 0);
    arstn = 1'b0;
    #1;
    chk("arst_scl", scl_o, 1);
    chk("arst_sda", sda_o, 1);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    slave_sda = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_scl", scl_o, 1);

    // cmd_valid held high: exactly one acceptance per completion
    wait_ready();
    acc = 0;
    nrsp = 0;
    for (int k = 0; k <= 3 * (CMD_LEN + 1); k++) begin
      if (k > 0) @(negedge clk);
      if (rsp_valid) nrsp++;
      if (k < 3 * (CMD_LEN + 1)) begin
        cmd_valid = 1'b1;
        din = 1'($urandom_range(0, 1));
        if (cmd_ready) begin
          cmd = 2'd3;
          acc++;
          x.dout = 1'b1;
          x.cyc = cyc + 1 + CMD_LEN;
          exp_q.push_back(x);
        end else begin
          cmd = 2'($urandom_range(0, 3));
        end
      end else begin
        cmd_valid = 1'b0;
      end
    end
    chk("hold_accepts", acc, 3);
    chk("hold_rsps", nrsp, 3);

    repeat (5) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
